// File: rtl/axis_shim_pkg.sv
// Shared definitions for the mesh ingress/egress shims: serializer FSM
// states, flit geometry helpers and the TKEEP-based flit count.
package axis_shim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Widest TKEEP the flit-count helper handles (TDATA up to 2048 bits).
  localparam int MAX_KEEP_WIDTH = 256;

  function automatic int calc_flit_width(input int tdata_width, input int sf);
    return tdata_width / sf;
  endfunction

  function automatic int calc_flit_bytes(input int tdata_width, input int sf);
    return tdata_width / sf / 8;
  endfunction

  // Flits needed to carry one beat. Non-last beats always use every slice;
  // a last beat stops at the flit holding the highest enabled byte. Holes
  // below that byte do not shorten the beat, and an empty TKEEP still
  // produces one flit so the tail marker reaches the router.
  function automatic int flits_needed(input logic [MAX_KEEP_WIDTH-1:0] tkeep,
                                      input logic                      tlast,
                                      input int                        sf,
                                      input int                        flit_bytes);
    int msb_plus1;
    int n;
    if (!tlast) return sf;
    msb_plus1 = 0;
    for (int b = 0; b < MAX_KEEP_WIDTH; b++) begin
      if (tkeep[b]) msb_plus1 = b + 1;
    end
    n = (msb_plus1 + flit_bytes - 1) / flit_bytes;
    if (n < 1) n = 1;
    if (n > sf) n = sf;
    return n;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for a downstream flit buffer of DEPTH slots. Starts full,
// decrements on each sent flit, increments on each returned credit.
// A return while already full is a protocol error: flagged by assertion,
// and the count saturates.
module noc_credit_counter #(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next credit count: simultaneous send and return cancel out.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch is inferred.
    count_d = count_q;
    unique case ({inc_i, dec_i})
      2'b10:   if (count_q != DEPTH_C) count_d = count_q + CNT_W'(1);
      2'b01:   if (count_q != '0)      count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Credit register, refilled to DEPTH on reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state updates use <= so every flop samples pre-edge values.
    if (rst_i) count_q <= DEPTH_C;
    else       count_q <= count_d;
  end

  assign avail_o = (count_q != '0);

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && (count_q == DEPTH_C)));

endmodule

// File: rtl/axis_flit_serializer.sv
// AXI-Stream to NoC flit injector. Each accepted beat is split into
// SERIALIZATION_FACTOR flits, least-significant slice first; the last beat
// of a packet is trimmed to the flits that hold enabled bytes. Flits are
// sent only while the downstream credit count is non-zero.
// Optional: define AXIS_FLIT_SER_STATS_EN to add the stat_flits, stat_pkts
// and stat_stall counters.
module axis_flit_serializer
  import axis_shim_pkg::*;
#(
  parameter int  TDATA_WIDTH          = 512,
  parameter int  DEST_WIDTH           = 6,
  parameter int  SERIALIZATION_FACTOR = 4,
  parameter int  FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH           = calc_flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
  localparam int KEEP_WIDTH           = TDATA_WIDTH / 8
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc_sync,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic [TDATA_WIDTH-1:0] axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  axis_tkeep,
  input  logic                   axis_tlast,
  input  logic [DEST_WIDTH-1:0]  axis_tdest,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in
`ifdef AXIS_FLIT_SER_STATS_EN
  ,
  output logic [31:0]            stat_flits,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_stall
`endif
);

  localparam int SF         = SERIALIZATION_FACTOR;
  localparam int FLIT_BYTES = calc_flit_bytes(TDATA_WIDTH, SERIALIZATION_FACTOR);
  localparam int IDX_W      = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W       = $clog2(SF + 1);

  ser_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TDATA_WIDTH-1:0] hold_data_q;
  logic [DEST_WIDTH-1:0]  hold_dest_q;
  logic                   hold_last_q;
  logic [NF_W-1:0]        nflits_q;
  logic [NF_W-1:0]        nflits_d;
  logic                   send_q;
  logic                   tail_q;
  logic [FLIT_WIDTH-1:0]  data_q;
  logic [DEST_WIDTH-1:0]  dest_q;

  logic                   credit_avail;
  logic                   fire;
  logic                   last_flit;
  logic                   accept;
  logic [FLIT_WIDTH-1:0]  slice;

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_credits (
    .clk_i   (clk_noc),
    .rst_i   (rst_noc_sync),
    .inc_i   (credit_in),
    .dec_i   (fire),
    .avail_o (credit_avail)
  );

  // A flit goes out whenever a beat is held and the registered count allows it;
  // a credit arriving this same cycle only helps from the next cycle on.
  assign fire      = (state_q == SEND) && credit_avail;
  assign last_flit = (NF_W'(idx_q) == (nflits_q - NF_W'(1)));
  // Ready while idle, and in the cycle the final flit of the held beat fires,
  // so back-to-back beats stream without a bubble.
  assign axis_tready = !rst_noc_sync && ((state_q == IDLE) || (fire && last_flit));
  assign accept      = axis_tvalid && axis_tready;
  assign slice       = FLIT_WIDTH'(hold_data_q >> (int'(idx_q) * FLIT_WIDTH));
  assign nflits_d    = NF_W'(flits_needed(MAX_KEEP_WIDTH'(axis_tkeep), axis_tlast,
                                          SF, FLIT_BYTES));

  // Beat holding register, loaded on every accepted beat.
  always_ff @(posedge clk_noc) begin
    // NOTE: the hold registers are deliberately not reset; the FSM returns to
    // IDLE on reset, so a stale beat is never read out.
    if (accept) begin
      hold_data_q <= axis_tdata;
      hold_dest_q <= axis_tdest;
      hold_last_q <= axis_tlast;
      nflits_q    <= nflits_d;
    end
  end

  // Serializer FSM with registered flit outputs.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q <= IDLE;
      idx_q   <= '0;
      send_q  <= 1'b0;
      tail_q  <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
    end else begin
      send_q <= fire;
      tail_q <= fire && hold_last_q && last_flit;
      if (fire) begin
        data_q <= slice;
        dest_q <= hold_dest_q;
        idx_q  <= idx_q + IDX_W'(1);
      end
      if (accept) begin
        idx_q   <= '0;
        state_q <= SEND;
      end else if (fire && last_flit) begin
        state_q <= IDLE;
      end
    end
  end

  assign send_out    = send_q;
  assign is_tail_out = tail_q;
  assign data_out    = data_q;
  assign dest_out    = dest_q;

`ifdef AXIS_FLIT_SER_STATS_EN
  logic [31:0] stat_flits_q;
  logic [31:0] stat_pkts_q;
  logic [31:0] stat_stall_q;

  // Free-running event counters; they wrap at 2^32.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      stat_flits_q <= '0;
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (fire)                              stat_flits_q <= stat_flits_q + 32'd1;
      if (fire && hold_last_q && last_flit)  stat_pkts_q  <= stat_pkts_q + 32'd1;
      if ((state_q == SEND) && !credit_avail) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_pkts  = stat_pkts_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_axis_flit_serializer.sv
// Directed bench for axis_flit_serializer (TDATA=512, SF=4, 128-bit flits,
// 4 credits). Optional stats checks build when AXIS_FLIT_SER_STATS_EN is defined.
module tb_axis_flit_serializer;

  localparam logic [127:0] S0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] S1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] S2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
  localparam logic [127:0] S3 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

  logic         clk = 1'b0;
  logic         rst;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic [5:0]   tdest;
  logic [127:0] data_out;
  logic [5:0]   dest_out;
  logic         is_tail;
  logic         send;
  logic         man_credit;
  logic         auto_ret;
  logic [1:0]   ret_pipe;
  wire          credit_in = man_credit | (auto_ret & ret_pipe[1]);
`ifdef AXIS_FLIT_SER_STATS_EN
  logic [31:0]  stat_flits;
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [127:0] data;
    logic [5:0]   dest;
    logic         tail;
    int           edge_n;
  } flit_t;

  flit_t flit_q[$];
  bit    trdy_log[int];

  always #5 clk = ~clk;

  axis_flit_serializer dut (
    .clk_noc      (clk),
    .rst_noc_sync (rst),
    .axis_tvalid  (tvalid),
    .axis_tready  (tready),
    .axis_tdata   (tdata),
    .axis_tkeep   (tkeep),
    .axis_tlast   (tlast),
    .axis_tdest   (tdest),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail),
    .send_out     (send),
    .credit_in    (credit_in)
`ifdef AXIS_FLIT_SER_STATS_EN
    ,
    .stat_flits   (stat_flits),
    .stat_pkts    (stat_pkts),
    .stat_stall   (stat_stall)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs flits and tready, and returns each credit two cycles after its flit.
  always @(negedge clk) begin
    trdy_log[cyc] = tready;
    if (send === 1'b1) flit_q.push_back('{data_out, dest_out, is_tail, cyc});
    ret_pipe = auto_ret ? {ret_pipe[0], send} : 2'b00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] s_const(input int i);
    case (i)
      0:       return S0;
      1:       return S1;
      2:       return S2;
      default: return S3;
    endcase
  endfunction

  function automatic logic [127:0] pat(input int b, input int i);
    logic [7:0] by;
    by = 8'((b << 4) | i);
    return {16{by}};
  endfunction

  function automatic logic [511:0] pat_beat(input int b);
    return {pat(b, 3), pat(b, 2), pat(b, 1), pat(b, 0)};
  endfunction

  task automatic do_reset();
    auto_ret   = 1'b0;
    man_credit = 1'b0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    tkeep      = '0;
    tdata      = '0;
    tdest      = '0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    flit_q.delete();
    @(negedge clk);
  endtask

  // Presents one beat and holds it until accepted; acc = accepting edge number.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [5:0] dst, output int acc);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tdest  = dst;
    tvalid = 1'b1;
    acc    = -1;
    for (int i = 0; i < 64; i++) begin
      if (tready === 1'b1) begin
        acc = cyc + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL beat_accept: tready never seen within 64 cycles");
    end
  endtask

  task automatic wait_flits(input int n, input int budget, input string tag);
    int i = 0;
    while (flit_q.size() < n && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (flit_q.size() != n) begin
      failures++;
      $display("FAIL %s_flit_count: got %0d want %0d", tag, flit_q.size(), n);
    end
  endtask

  task automatic test_reset();
    tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; tdest = '0;
    man_credit = 1'b0; auto_ret = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b want 0", tready); end
    checks++; if (send !== 1'b0) begin failures++; $display("FAIL rst_send: got %b want 0", send); end
    checks++; if (is_tail !== 1'b0) begin failures++; $display("FAIL rst_tail: got %b want 0", is_tail); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL rst_data: got %h want 0", data_out); end
    checks++; if (dest_out !== '0) begin failures++; $display("FAIL rst_dest: got %h want 0", dest_out); end
`ifdef AXIS_FLIT_SER_STATS_EN
    checks++; if (stat_flits !== 32'd0) begin failures++; $display("FAIL rst_stat_flits: got %0d want 0", stat_flits); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tready !== 1'b1) begin failures++; $display("FAIL post_rst_tready: got %b want 1", tready); end
    checks++; if (send !== 1'b0) begin failures++; $display("FAIL post_rst_send: got %b want 0", send); end
  endtask

  task automatic test_single_beat();
    int acc;
    do_reset();
    auto_ret = 1'b1;
    send_beat({S3, S2, S1, S0}, {64{1'b1}}, 1'b1, 6'h2A, acc);
    tvalid = 1'b0;
    wait_flits(4, 20, "t1");
    for (int i = 0; i < 4 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i].data !== s_const(i)) begin failures++; $display("FAIL t1_data[%0d]: got %h want %h", i, flit_q[i].data, s_const(i)); end
      checks++; if (flit_q[i].tail !== (i == 3)) begin failures++; $display("FAIL t1_tail[%0d]: got %b want %b", i, flit_q[i].tail, (i == 3)); end
      checks++; if (flit_q[i].dest !== 6'h2A) begin failures++; $display("FAIL t1_dest[%0d]: got %h want 2a", i, flit_q[i].dest); end
      checks++; if (flit_q[i].edge_n != acc + 1 + i) begin failures++; $display("FAIL t1_cycle[%0d]: got %0d want %0d", i, flit_q[i].edge_n, acc + 1 + i); end
    end
  endtask

  task automatic test_tkeep_trim();
    logic [63:0] keeps [5] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0001_FFFF, 64'h0,
                               64'h0000_0000_0001_0000, 64'h8000_0000_0000_0000};
    int          nexp  [5] = '{1, 2, 1, 2, 4};
    int acc;
    do_reset();
    auto_ret = 1'b1;
    for (int v = 0; v < 5; v++) begin
      flit_q.delete();
      send_beat({S3, S2, S1, S0}, keeps[v], 1'b1, 6'h05, acc);
      tvalid = 1'b0;
      wait_flits(nexp[v], 20, $sformatf("t2_v%0d", v));
      for (int i = 0; i < nexp[v] && i < flit_q.size(); i++) begin
        checks++; if (flit_q[i].data !== s_const(i)) begin failures++; $display("FAIL t2_v%0d_data[%0d]: got %h want %h", v, i, flit_q[i].data, s_const(i)); end
        checks++; if (flit_q[i].tail !== (i == nexp[v] - 1)) begin failures++; $display("FAIL t2_v%0d_tail[%0d]: got %b want %b", v, i, flit_q[i].tail, (i == nexp[v] - 1)); end
      end
    end
  endtask

  task automatic test_credit_stall();
    int acc1, acc2, e_cred;
    do_reset();
    send_beat({S3, S2, S1, S0}, {64{1'b1}}, 1'b0, 6'h11, acc1);
    send_beat(pat_beat(2), {64{1'b1}}, 1'b1, 6'h11, acc2);
    tvalid = 1'b0;
    wait_flits(4, 20, "t3_stall");
    checks++; if (send !== 1'b0) begin failures++; $display("FAIL t3_send_idle: got %b want 0", send); end
    checks++; if (tready !== 1'b0) begin failures++; $display("FAIL t3_tready_stalled: got %b want 0", tready); end
    checks++; if (acc2 != acc1 + 4) begin failures++; $display("FAIL t3_beat2_accept: got %0d want %0d", acc2, acc1 + 4); end
    @(negedge clk);
    man_credit = 1'b1;
    e_cred     = cyc + 1;
    @(negedge clk);
    man_credit = 1'b0;
    wait_flits(5, 10, "t3_one_credit");
    if (flit_q.size() >= 5) begin
      checks++; if (flit_q[4].edge_n != e_cred + 1) begin failures++; $display("FAIL t3_credit_latency: got %0d want %0d", flit_q[4].edge_n, e_cred + 1); end
      checks++; if (flit_q[4].data !== pat(2, 0)) begin failures++; $display("FAIL t3_data5: got %h want %h", flit_q[4].data, pat(2, 0)); end
      checks++; if (flit_q[4].tail !== 1'b0) begin failures++; $display("FAIL t3_tail5: got %b want 0", flit_q[4].tail); end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, acc3;
    bit exp_rdy;
    do_reset();
    auto_ret = 1'b1;
    send_beat(pat_beat(1), 64'h0, 1'b0, 6'h3F, acc1);
    send_beat(pat_beat(2), 64'h0, 1'b0, 6'h3F, acc2);
    send_beat(pat_beat(3), {64{1'b1}}, 1'b1, 6'h3F, acc3);
    tvalid = 1'b0;
    wait_flits(12, 40, "t4");
    checks++; if (acc2 != acc1 + 4) begin failures++; $display("FAIL t4_accept2: got %0d want %0d", acc2, acc1 + 4); end
    checks++; if (acc3 != acc1 + 8) begin failures++; $display("FAIL t4_accept3: got %0d want %0d", acc3, acc1 + 8); end
    for (int k = 0; k < 12 && k < flit_q.size(); k++) begin
      checks++; if (flit_q[k].data !== pat(k / 4 + 1, k % 4)) begin failures++; $display("FAIL t4_data[%0d]: got %h want %h", k, flit_q[k].data, pat(k / 4 + 1, k % 4)); end
      checks++; if (flit_q[k].tail !== (k == 11)) begin failures++; $display("FAIL t4_tail[%0d]: got %b want %b", k, flit_q[k].tail, (k == 11)); end
      checks++; if (flit_q[k].edge_n != acc1 + 1 + k) begin failures++; $display("FAIL t4_cycle[%0d]: got %0d want %0d", k, flit_q[k].edge_n, acc1 + 1 + k); end
    end
    // tready is high only in the cycles that fire flits 4 and 8.
    for (int j = 0; j <= 10; j++) begin
      exp_rdy = (j == 3) || (j == 7);
      checks++; if (trdy_log[acc1 + j] != exp_rdy) begin failures++; $display("FAIL t4_tready[+%0d]: got %b want %b", j, trdy_log[acc1 + j], exp_rdy); end
    end
  endtask

  task automatic test_credit_coincident();
    int acc1, acc2, e_cred;
    do_reset();
    fork
      begin
        send_beat(pat_beat(1), {64{1'b1}}, 1'b0, 6'h07, acc1);
        send_beat(pat_beat(2), {64{1'b1}}, 1'b1, 6'h07, acc2);
        tvalid = 1'b0;
      end
      begin
        // Return a credit in the cycle flit 4 fires with one credit left.
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          #1;
          if (flit_q.size() == 3) break;
        end
        man_credit = 1'b1;
        @(negedge clk);
        man_credit = 1'b0;
      end
    join
    wait_flits(5, 20, "t5_at1");
    for (int i = 1; i < 5 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i].edge_n != flit_q[0].edge_n + i) begin failures++; $display("FAIL t5_cycle[%0d]: got %0d want %0d", i, flit_q[i].edge_n, flit_q[0].edge_n + i); end
    end
    @(negedge clk);
    man_credit = 1'b1;
    e_cred     = cyc + 1;
    @(negedge clk);
    man_credit = 1'b0;
    checks++; if (send !== 1'b0) begin failures++; $display("FAIL t5_at0_no_fire: got %b want 0", send); end
    wait_flits(6, 10, "t5_at0");
    if (flit_q.size() >= 6) begin
      checks++; if (flit_q[5].edge_n != e_cred + 1) begin failures++; $display("FAIL t5_at0_cycle: got %0d want %0d", flit_q[5].edge_n, e_cred + 1); end
      checks++; if (flit_q[5].data !== pat(2, 1)) begin failures++; $display("FAIL t5_at0_data: got %h want %h", flit_q[5].data, pat(2, 1)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int acc;
    do_reset();
    fork
      begin
        send_beat({S3, S2, S1, S0}, {64{1'b1}}, 1'b1, 6'h15, acc);
        tvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          #1;
          if (flit_q.size() == 2) break;
        end
`ifdef AXIS_FLIT_SER_STATS_EN
        checks++; if (stat_flits !== 32'd2) begin failures++; $display("FAIL t6_stat_before: got %0d want 2", stat_flits); end
`endif
        rst = 1'b1;
        @(negedge clk);
        checks++; if (send !== 1'b0) begin failures++; $display("FAIL t6_send: got %b want 0", send); end
        checks++; if (is_tail !== 1'b0) begin failures++; $display("FAIL t6_tail: got %b want 0", is_tail); end
        checks++; if (data_out !== '0) begin failures++; $display("FAIL t6_data: got %h want 0", data_out); end
        checks++; if (dest_out !== '0) begin failures++; $display("FAIL t6_dest: got %h want 0", dest_out); end
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL t6_tready_in_rst: got %b want 0", tready); end
`ifdef AXIS_FLIT_SER_STATS_EN
        checks++; if (stat_flits !== 32'd0) begin failures++; $display("FAIL t6_stat_after: got %0d want 0", stat_flits); end
`endif
        rst = 1'b0;
      end
    join
    wait_flits(2, 4, "t6_dropped");
    checks++; if (tready !== 1'b1) begin failures++; $display("FAIL t6_tready_after: got %b want 1", tready); end
    flit_q.delete();
    send_beat(pat_beat(6), {64{1'b1}}, 1'b1, 6'h15, acc);
    tvalid = 1'b0;
    wait_flits(4, 20, "t6_next_pkt");
    for (int i = 0; i < 4 && i < flit_q.size(); i++) begin
      checks++; if (flit_q[i].data !== pat(6, i)) begin failures++; $display("FAIL t6_next_data[%0d]: got %h want %h", i, flit_q[i].data, pat(6, i)); end
      checks++; if (flit_q[i].tail !== (i == 3)) begin failures++; $display("FAIL t6_next_tail[%0d]: got %b want %b", i, flit_q[i].tail, (i == 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_tkeep_trim();
    test_credit_stall();
    test_back_to_back();
    test_credit_coincident();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
